// File: rtl/qspi_cmd_pkg.sv
// Shared types and constants for the QSPI command/transaction engine.
package qspi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA
  } parse_state_t;

  localparam int         CMD_READ_BIT = 0;
  localparam int         ADDR_BYTES   = 3;
  localparam logic [7:0] IDLE_BYTE    = 8'hFF;

  function automatic logic is_last_addr_byte(input logic [1:0] cnt);
    return cnt == 2'(ADDR_BYTES - 1);
  endfunction

endpackage

// File: rtl/qspi_cmd_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop in one cycle are both honored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/qspi_cmd.sv
// Command/transaction engine: parses cmd + 24-bit address from the QSPI byte stream,
// posts writes to a byte-wide memory port and prefetches read bytes for the transmitter.
module qspi_cmd
  import qspi_cmd_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int WFIFO_DEPTH = 4,
  parameter int RFIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err_underrun,
  output logic              err_overflow
);
  localparam int WFW = ADDR_W + 8;
  localparam int WCW = $clog2(WFIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RFIFO_DEPTH) + 1;

  parse_state_t      state;
  parse_state_t      state_next;
  logic              cmd_write;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              cmd_byte;
  logic              addr_byte;
  logic              wdata_byte;
  logic              fetch_phase;

  logic              wfifo_push;
  logic              wfifo_pop;
  logic              wfifo_full;
  logic              wfifo_empty;
  logic [WFW-1:0]    wfifo_head;
  logic [WCW-1:0]    wfifo_count;
  logic              rfifo_push;
  logic              rfifo_pop;
  logic              rfifo_full;
  logic              rfifo_empty;
  logic [7:0]        rfifo_head;
  logic [RCW-1:0]    rfifo_count;

  logic              rd_discard;
  logic              read_inflight;
  logic              fetch_room;
  logic              write_issue;
  logic              read_issue;
  logic              read_ack;

  // ---------------- parser FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_CMD;
    end else begin
      case (state)
        ST_CMD:  if (rd_valid) state_next = ST_ADDR;
        ST_ADDR: if (rd_valid && is_last_addr_byte(byte_cnt))
                   state_next = cmd_write ? ST_WDATA : ST_RDATA;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    cmd_byte    = (state == ST_CMD)   && rd_valid && !start;
    addr_byte   = (state == ST_ADDR)  && rd_valid && !start;
    wdata_byte  = (state == ST_WDATA) && rd_valid && !start;
    fetch_phase = (state == ST_RDATA) && !start;
  end

  // Address counter: loaded MSB first, then advances per write byte or issued read.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_write <= 1'b0;
      byte_cnt  <= 2'd0;
      addr_cnt  <= '0;
    end else if (start) begin
      byte_cnt  <= 2'd0;
      addr_cnt  <= '0;
    end else begin
      if (cmd_byte) cmd_write <= rd_data[CMD_READ_BIT];
      if (addr_byte) begin
        addr_cnt <= {addr_cnt[ADDR_W-9:0], rd_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (wdata_byte || read_issue) addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // ---------------- FIFOs ----------------
  assign wfifo_push = wdata_byte && !wfifo_full;
  assign wfifo_pop  = mem_req && mem_we && mem_ack;

  sync_fifo #(.WIDTH(WFW), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (wfifo_push),
    .wdata ({addr_cnt, rd_data}),
    .pop   (wfifo_pop),
    .rdata (wfifo_head),
    .full  (wfifo_full),
    .empty (wfifo_empty),
    .count (wfifo_count)
  );

  assign read_ack   = mem_req && !mem_we && mem_ack;
  assign rfifo_push = read_ack && !rd_discard && !start && !rfifo_full;
  assign rfifo_pop  = wr_valid && !rfifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (rfifo_push),
    .wdata (mem_rdata),
    .pop   (rfifo_pop),
    .rdata (rfifo_head),
    .full  (rfifo_full),
    .empty (rfifo_empty),
    .count (rfifo_count)
  );

  // ---------------- memory port ----------------
  // Handshake: mem_req rises with mem_we/mem_addr/mem_wdata and all four hold until
  // the cycle mem_ack is seen high; mem_req then drops for at least one cycle.
  assign read_inflight = mem_req && !mem_we;
  assign fetch_room    = (int'(rfifo_count) + int'(read_inflight)) < RFIFO_DEPTH;
  assign write_issue   = !mem_req && !wfifo_empty;
  assign read_issue    = !mem_req && wfifo_empty && fetch_phase && fetch_room;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      rd_discard <= 1'b0;
    end else if (mem_req) begin
      if (mem_ack) begin
        mem_req    <= 1'b0;
        rd_discard <= 1'b0;
      end else if (start && !mem_we) begin
        rd_discard <= 1'b1;
      end
    end else if (write_issue) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wfifo_head[WFW-1:8];
      mem_wdata <= wfifo_head[7:0];
    end else if (read_issue) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= addr_cnt;
    end
  end

  // ---------------- status ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_valid && rfifo_empty && state == ST_RDATA) err_underrun <= 1'b1;
      if (wdata_byte && wfifo_full)                     err_overflow <= 1'b1;
    end
  end

  assign wr_data = rfifo_empty ? IDLE_BYTE : rfifo_head;
  assign busy    = (state != ST_IDLE) || (wfifo_count != '0) || !rfifo_empty || mem_req;

endmodule

// File: tb/tb_qspi_cmd.sv
// Self-checking bench for qspi_cmd: directed plan scenarios plus randomized transactions
// checked against a byte-addressed memory model and an expected-write queue.
module tb_qspi_cmd;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        err_underrun;
  logic        err_overflow;

  qspi_cmd #(.ADDR_W(24), .WFIFO_DEPTH(4), .RFIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_overflow (err_overflow)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];           // expected {addr, data} writes, in port order
  logic [7:0]  ref_mem [int];      // host-visible memory image after every accepted write
  logic [7:0]  dev_mem [int];      // memory device contents
  int lat_min = 0;
  int lat_max = 0;
  bit hold_ack = 1'b0;
  int rd_ack_cnt = 0;
  int resp_wait = 0;
  int resp_lat = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] preload(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : preload(a);
  endfunction

  // Memory device: acks after a random latency, checks every write against exp_q.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req || reset) begin
        resp_wait = 0;
      end else if (!hold_ack) begin
        if (resp_wait >= resp_lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            if (exp_q.size() == 0) chk("wr_extra", 32'(exp_q.size()), 1);
            else                   chk("wr_port", {mem_addr, mem_wdata}, exp_q.pop_front());
            dev_mem[int'(mem_addr)] = mem_wdata;
          end else begin
            mem_rdata = dev_mem.exists(int'(mem_addr)) ? dev_mem[int'(mem_addr)] : preload(mem_addr);
            rd_ack_cnt++;
          end
          resp_wait = 0;
          resp_lat  = $urandom_range(lat_max, lat_min);
        end else begin
          resp_wait++;
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rd_data  = b;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    idle(gap);
  endtask

  task automatic consume();
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic send_header(input logic is_write, input logic [23:0] a, input int gap);
    logic [7:0] cmd;
    cmd    = 8'($urandom_range(0, 255));
    cmd[0] = is_write;
    pulse_start();
    send_byte(cmd, gap);
    send_byte(a[23:16], gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
  endtask

  // Bytes beyond n_accept are expected to be dropped by a full write FIFO.
  task automatic host_write(input logic [23:0] a, input int n, input int n_accept, input int gap);
    logic [7:0]  b;
    logic [23:0] wa;
    send_header(1'b1, a, gap);
    for (int i = 0; i < n; i++) begin
      b  = 8'($urandom_range(0, 255));
      wa = a + 24'(i);
      if (i < n_accept) begin
        exp_q.push_back({wa, b});
        ref_mem[int'(wa)] = b;
      end
      send_byte(b, gap);
    end
  endtask

  task automatic read_check(input logic [23:0] a, input int n, input int first_wait, input int step);
    idle(first_wait);
    for (int i = 0; i < n; i++) begin
      chk("rd_data", 32'(wr_data), 32'(ref_rd(a + 24'(i))));
      consume();
      idle(step);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && !mem_req) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          base;
    bit          found;
    logic [23:0] a;
    int          n;
    int          gap;

    reset = 1'b1; start = 1'b0; rd_data = 8'd0; rd_valid = 1'b0; wr_valid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);

    chk("rst_wr_data", 32'(wr_data), 32'hFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_underrun", 32'(err_underrun), 0);
    chk("rst_overflow", 32'(err_overflow), 0);

    // Directed write with request latency check.
    lat_min = 1; lat_max = 1;
    send_header(1'b1, 24'h123456, 0);
    exp_q.push_back({24'h123456, 8'hAA}); ref_mem[int'(24'h123456)] = 8'hAA;
    exp_q.push_back({24'h123457, 8'hBB}); ref_mem[int'(24'h123457)] = 8'hBB;
    send_byte(8'hAA, 0);
    chk("wr_req_t1", 32'(mem_req), 0);
    send_byte(8'hBB, 0);
    chk("wr_req_t2", 32'(mem_req), 1);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 32'h123456);
    wait_drain();
    chk("wr_busy", 32'(busy), 1);
    chk("wr_no_overflow", 32'(err_overflow), 0);

    // Directed read: latency, prefetch depth, data sequence.
    lat_min = 2; lat_max = 2;
    base = rd_ack_cnt;
    send_header(1'b0, 24'h000010, 0);
    chk("rd_req_t1", 32'(mem_req), 0);
    idle(1);
    chk("rd_req_t2", 32'(mem_req), 1);
    chk("rd_we", 32'(mem_we), 0);
    chk("rd_addr", 32'(mem_addr), 32'h10);
    idle(30);
    chk("prefetch_depth", 32'(rd_ack_cnt - base), 2);
    read_check(24'h000010, 3, 0, 8);
    idle(20);
    chk("prefetch_refill", 32'(rd_ack_cnt - base), 5);

    // Address wrap for writes and reads.
    host_write(24'hFFFFFF, 2, 2, 1);
    wait_drain();
    send_header(1'b0, 24'hFFFFFE, 1);
    read_check(24'hFFFFFE, 4, 12, 8);

    // Overflow: acks held, six back-to-back bytes, four survive.
    do_reset();
    hold_ack = 1'b1;
    host_write(24'h000200, 6, 4, 0);
    idle(2);
    chk("ovf_flag", 32'(err_overflow), 1);
    chk("ovf_busy", 32'(busy), 1);
    hold_ack = 1'b0;
    wait_drain();
    send_header(1'b0, 24'h000203, 0);
    read_check(24'h000203, 3, 12, 8);

    // Underrun: consume before slow data arrives.
    do_reset();
    lat_min = 20; lat_max = 20;
    send_header(1'b0, 24'h000300, 0);
    idle(1);
    chk("udr_idle_byte", 32'(wr_data), 32'hFF);
    consume();
    chk("udr_flag", 32'(err_underrun), 1);
    idle(30);
    chk("udr_late_data", 32'(wr_data), 32'(ref_rd(24'h000300)));

    // Ordering: posted writes then read of the same bytes.
    lat_min = 5; lat_max = 5;
    host_write(24'h000400, 2, 2, 0);
    send_header(1'b0, 24'h000400, 0);
    read_check(24'h000400, 2, 80, 10);

    // Abort: start while a read is in flight; its data must be discarded.
    lat_min = 3; lat_max = 3;
    send_header(1'b0, 24'h000500, 0);
    idle(20);
    chk("abort_pre", 32'(wr_data), 32'(ref_rd(24'h000500)));
    consume();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req && !mem_we) found = 1'b1;
      else idle(1);
    end
    if (!found) chk("abort_wait_req", 0, 1);
    send_header(1'b0, 24'h000600, 0);
    chk("abort_flushed", 32'(wr_data), 32'hFF);
    read_check(24'h000600, 2, 15, 8);

    // Randomized transactions.
    do_reset();
    for (int it = 0; it < 14; it++) begin
      lat_min = $urandom_range(0, 2);
      lat_max = lat_min + $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
      else                          a = 24'($urandom);
      n   = $urandom_range(1, 4);
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        host_write(a, n, n, gap);
        wait_drain();
      end else begin
        send_header(1'b0, a, gap);
        read_check(a, n, lat_max + 4, lat_max + 4);
      end
    end
    chk("rand_no_overflow", 32'(err_overflow), 0);
    chk("rand_no_underrun", 32'(err_underrun), 0);
    chk("rand_all_written", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_cmd.md
# qspi_cmd

Command/transaction engine in the `clk` domain, directly downstream of the QSPI slave front end. It consumes the front end's byte stream (`start`, `rd_data`, `rd_valid`), parses a command byte and a 24-bit address, then either streams write bytes to a byte-wide memory port or prefetches read bytes into `wr_data` ahead of the transmitter's `wr_valid` consume strobes. Ordering between back-to-back transactions is preserved by draining posted writes before any read fetch.

## Interface
- `ADDR_W`, 24, memory address width; the address phase is always 3 bytes.
- `WFIFO_DEPTH`, 4, posted-write FIFO entries of {addr, data}; power of two.
- `RFIFO_DEPTH`, 2, read prefetch FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: new transaction (chip-select asserted).
- `rd_data`  in  8  received byte, valid when `rd_valid` pulses.
- `rd_valid`  in  1  one-cycle pulse per received byte.
- `wr_data`  out  8  byte offered to the transmitter (read-FIFO head, `8'hFF` when empty).
- `wr_valid`  in  1  one-cycle pulse: head byte consumed, advance.
- `mem_req`  out  1  access request, held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req`.
- `mem_addr`  out  ADDR_W  access address; stable while `mem_req`.
- `mem_wdata`  out  8  write data; stable while `mem_req`.
- `mem_ack`  in  1  access done; `mem_rdata` valid this cycle.
- `mem_rdata`  in  8  read data.
- `busy`  out  1  parser not IDLE, or either FIFO non-empty, or `mem_req` high.
- `err_underrun`  out  1  sticky: `wr_valid` while read FIFO empty.
- `err_overflow`  out  1  sticky: write byte arrived with write FIFO full (byte dropped).

## Operation
- Parser states: IDLE → CMD → ADDR → {WDATA | RDATA}.
- `start` in any state → CMD; flushes read FIFO; cancels read fetching; address byte counter := 0. Write FIFO is NOT flushed (posted writes carry their own address).
- CMD: next `rd_valid` latches command; `rd_data[0]==0` → read, `==1` → write; bits [7:1] ignored. → ADDR.
- ADDR: three `rd_valid` bytes, MSB first, into the address counter; after the third → WDATA (write) or RDATA (read).
- WDATA: each `rd_valid` pushes {addr, rd_data} into the write FIFO; addr += 1, wrapping at 2^ADDR_W. If full: drop, set `err_overflow`, addr still increments.
- RDATA: `rd_valid` ignored. Fetch engine issues reads while (read FIFO count + outstanding) < RFIFO_DEPTH AND write FIFO empty; at most one outstanding; addr += 1 per issued read, wrapping.
- `wr_valid` pops the read FIFO; if empty, no pop, set `err_underrun`. Pop and push in the same cycle are both honored.
- `rd_valid`/`wr_valid` in IDLE are ignored (except `wr_valid` underrun rule in RDATA only).
- Memory port: write FIFO drains whenever non-empty (priority over read fetch). An in-flight request is never abandoned: if `start` arrives during an outstanding read, the handshake completes and `mem_rdata` is discarded.
- Reset: parser IDLE, FIFOs empty, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `wr_data`=`8'hFF`, `busy`=0, both error flags 0.

## Timing
- `rd_valid` of a write byte at cycle T → FIFO push at T+1 → `mem_req` at T+2 if port idle.
- Third address byte (`rd_valid`) at T in a read → first `mem_req` at T+2 if write FIFO empty.
- `mem_ack` at T → byte visible on `wr_data` at T+1 (if FIFO was empty); next `mem_req` no earlier than T+1.
- `wr_valid` at T → `wr_data` shows next entry at T+1.
- Back-to-back `rd_valid` every cycle supported; `mem_ack` may come in the same cycle `mem_req` rises.
- Host must allow ≥ (2 + mem latency) `clk` cycles between last address byte and first consume.

## Structure
- `qspi_cmd_pkg`: parser state enum, `CMD_READ_BIT` (=0), `ADDR_BYTES` (=3), `IDLE_BYTE` (=8'hFF).
- Sub-module `sync_fifo` (WIDTH, DEPTH; push/pop/full/empty/count, first-word-fall-through), instantiated twice.

## Test plan
- Write: start, 8'h01, 8'h12,8'h34,8'h56, 8'hAA,8'hBB → writes 8'hAA@24'h123456, 8'hBB@24'h123457, in order.
- Read: memory preloaded; start, 8'h00, 8'h00,8'h00,8'h10, three `wr_valid` → `wr_data` sequence mem[0x10],[0x11],[0x12]; prefetch never >2 ahead.
- Wrap: write at 24'hFFFFFF with 2 bytes → second lands at 24'h000000.
- Overflow: `mem_ack` held low, 6 write bytes → 4 queued, `err_overflow`=1, 2 dropped.
- Underrun: read with `mem_ack` delayed 20 cycles, `wr_valid` early → `wr_data`=8'hFF, `err_underrun`=1.
- Ordering/abort: write 2 bytes, immediate start + read of same address, `mem_ack` slow → read returns newly written data; `start` mid-read drains in-flight ack, FIFO flushed.
